pipe_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
package pipe_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // MEM holds the younger result, so it beats WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_rw,
        input logic [4:0] wb_rd,
        input logic       wb_rw
    );
        if (mem_rw && (mem_rd != 5'd0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects for both source operands.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_rw,
    input  logic [4:0] wb_rd,
    input  logic       wb_rw,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    always_comb begin
        fwd_a = fwd_sel(ex_rs1, mem_rd, mem_rw, wb_rd, wb_rw);
        fwd_b = fwd_sel(ex_rs2, mem_rd, mem_rw, wb_rd, wb_rw);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central enable/flush sequencer for the 5-stage pipeline: forwarding, load-use
// stalls, branch flushes, data-memory wait freeze with timeout, perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_md,
    input  logic             ex_br_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_rw,
    input  logic [4:0]       wb_rd,
    input  logic             wb_rw,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    state_e           state;
    logic [TMR_W-1:0] timer;
    logic             tmo;
    logic             freeze;
    logic             load_use;
    logic             do_branch;
    logic             do_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    fwd_unit u_fwd (
        .ex_rs1 (ex_rs1),
        .ex_rs2 (ex_rs2),
        .mem_rd (mem_rd),
        .mem_rw (mem_rw),
        .wb_rd  (wb_rd),
        .wb_rw  (wb_rw),
        .fwd_a  (fwd_a),
        .fwd_b  (fwd_b)
    );

    always_comb begin
        tmo       = (state == WAIT) && (timer == TMR_W'(TIMEOUT - 1));
        freeze    = mem_req && !mem_ready && !tmo;
        load_use  = ex_md && (ex_rd != 5'd0) &&
                    ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));
        // A branch held in EX through a freeze fires on the thaw cycle.
        do_branch = ex_br_taken && !freeze;
        do_stall  = load_use && !freeze && !ex_br_taken;
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (do_branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (do_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            timer <= '0;
        end else begin
            case (state)
                RUN: begin
                    timer <= '0;
                    if (freeze)
                        state <= WAIT;
                end
                default: begin
                    if (freeze) begin
                        timer <= timer + 1'b1;
                    end else begin
                        state <= RUN;
                        timer <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
        end else begin
            if (cnt_clr) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
                wait_cnt  <= '0;
            end else begin
                if (do_stall)  stall_cnt <= sat_inc(stall_cnt);
                if (do_branch) flush_cnt <= sat_inc(flush_cnt);
                if (freeze)    wait_cnt  <= sat_inc(wait_cnt);
            end
            if (tmo)
                mem_err <= 1'b1;
            else if (cnt_clr)
                mem_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (4-bit counters, TIMEOUT 16).
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use1, id_use2, ex_md, ex_br_taken, mem_rw, wb_rw;
    logic mem_req, mem_ready, cnt_clr;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

    pipe_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(16), .TMR_W(5)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_md(ex_md),
        .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .mem_rw(mem_rw),
        .wb_rd(wb_rd), .wb_rw(wb_rw), .mem_req(mem_req), .mem_ready(mem_ready),
        .cnt_clr(cnt_clr), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    // Expected word: {en[4:0], flush[2:0], fwd_a, fwd_b, mem_err, stall, flush, wait}
    typedef struct {
        string       nm;
        logic [24:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_sc = 0, m_fc = 0, m_wc = 0;
    bit   m_err = 1'b0;

    localparam int C_RUN = 0, C_STALL = 1, C_BR = 2, C_FRZ = 3, C_TMO = 4;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [24:0] act;
            e   = q.pop_front();
            act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b, mem_err,
                   stall_cnt, flush_cnt, wait_cnt};
            n_chk++;
            if (act === e.v)
                n_pass++;
            else
                $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
        end
    end

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
    endfunction

    task automatic cyc(input string nm, input int cls, input logic [1:0] fa,
                       input logic [1:0] fb, input bit clr);
        exp_t x;
        logic [4:0] en;
        logic [2:0] fl;
        logic [CW-1:0] sc, fc, wc;
        case (cls)
            C_STALL: begin en = 5'b00111; fl = 3'b010; end
            C_BR:    begin en = 5'b11111; fl = 3'b110; end
            C_FRZ:   begin en = 5'b00001; fl = 3'b001; end
            default: begin en = 5'b11111; fl = 3'b000; end
        endcase
        sc = CW'(m_sc);
        fc = CW'(m_fc);
        wc = CW'(m_wc);
        x.nm = nm;
        x.v  = {en, fl, fa, fb, m_err, sc, fc, wc};
        cnt_clr = clr;
        q.push_back(x);
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        if (clr) begin
            m_sc = 0; m_fc = 0; m_wc = 0;
        end else begin
            if (cls == C_STALL) m_sc = sat(m_sc);
            if (cls == C_BR)    m_fc = sat(m_fc);
            if (cls == C_FRZ)   m_wc = sat(m_wc);
        end
        if (cls == C_TMO)  m_err = 1'b1;
        else if (clr)      m_err = 1'b0;
    endtask

    task automatic quiet();
        id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_md = 0; ex_br_taken = 0;
        mem_rd = 0; mem_rw = 0; wb_rd = 0; wb_rw = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_load_use();
        ex_md = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1; id_rs2 = 1; id_use2 = 1;
    endtask

    initial begin
        quiet();
        cnt_clr = 0;
        reset   = 0;
        @(posedge clk);
        #1;
        cyc("reset_state", C_RUN, 2'b00, 2'b00, 0);
        reset = 1;
        cyc("run_idle", C_RUN, 2'b00, 2'b00, 0);

        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        set_load_use();
        cyc("lu_stall", C_STALL, 2'b00, 2'b00, 0);
        quiet();
        cyc("lu_after", C_RUN, 2'b00, 2'b00, 0);
        ex_md = 1; ex_rd = 0; id_rs1 = 0; id_use1 = 1;
        cyc("lu_x0", C_RUN, 2'b00, 2'b00, 0);
        ex_rd = 5; id_rs1 = 5; id_use1 = 0;
        cyc("lu_nouse", C_RUN, 2'b00, 2'b00, 0);
        ex_md = 0; id_use1 = 1;
        cyc("lu_noload", C_RUN, 2'b00, 2'b00, 0);
        quiet();
        cyc("clr1", C_RUN, 2'b00, 2'b00, 1);

        // branch beats load-use
        set_load_use();
        ex_br_taken = 1;
        cyc("br_over_lu", C_BR, 2'b00, 2'b00, 0);
        quiet();
        cyc("br_after", C_RUN, 2'b00, 2'b00, 0);

        // memory wait: ready low 3 cycles
        mem_req = 1;
        for (int i = 0; i < 3; i++) cyc("frz3", C_FRZ, 2'b00, 2'b00, 0);
        mem_ready = 1;
        cyc("frz_release", C_RUN, 2'b00, 2'b00, 0);
        cyc("ready_first", C_RUN, 2'b00, 2'b00, 0);
        quiet();
        cyc("frz_after", C_RUN, 2'b00, 2'b00, 0);

        // branch held through a freeze flushes on thaw
        mem_req = 1; ex_br_taken = 1;
        cyc("br_in_frz", C_FRZ, 2'b00, 2'b00, 0);
        mem_ready = 1;
        cyc("br_thaw", C_BR, 2'b00, 2'b00, 0);
        quiet();
        cyc("clr2", C_RUN, 2'b00, 2'b00, 1);

        // timeout: 16 freeze cycles, release on 16th WAIT cycle
        mem_req = 1;
        for (int i = 0; i < 16; i++) cyc("tmo_frz", C_FRZ, 2'b00, 2'b00, 0);
        cyc("tmo_rel", C_TMO, 2'b00, 2'b00, 0);
        quiet();
        cyc("err_set", C_RUN, 2'b00, 2'b00, 0);
        cyc("err_sticky", C_RUN, 2'b00, 2'b00, 1);
        cyc("err_clr", C_RUN, 2'b00, 2'b00, 0);

        // timeout and cnt_clr together: error set wins
        mem_req = 1;
        for (int i = 0; i < 16; i++) cyc("tmo2_frz", C_FRZ, 2'b00, 2'b00, 0);
        cyc("tmo2_rel_clr", C_TMO, 2'b00, 2'b00, 1);
        quiet();
        cyc("set_wins", C_RUN, 2'b00, 2'b00, 0);

        // forwarding
        mem_rd = 7; mem_rw = 1; wb_rd = 7; wb_rw = 1; ex_rs1 = 7; ex_rs2 = 0;
        cyc("fwd_mem_beats_wb", C_RUN, 2'b10, 2'b00, 0);
        mem_rw = 0;
        cyc("fwd_wb_only", C_RUN, 2'b01, 2'b00, 0);
        mem_rd = 3; mem_rw = 1; wb_rd = 9; wb_rw = 1; ex_rs1 = 3; ex_rs2 = 9;
        cyc("fwd_split", C_RUN, 2'b10, 2'b01, 0);
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        cyc("fwd_x0", C_RUN, 2'b00, 2'b00, 0);
        mem_rd = 4; mem_rw = 0; wb_rd = 4; wb_rw = 0; ex_rs1 = 4; ex_rs2 = 4;
        cyc("fwd_nowrite", C_RUN, 2'b00, 2'b00, 0);
        quiet();

        // 20 stalls saturate the 4-bit counter
        set_load_use();
        for (int i = 0; i < 20; i++) cyc("sat_stall", C_STALL, 2'b00, 2'b00, 0);
        quiet();
        cyc("sat_hold", C_RUN, 2'b00, 2'b00, 0);

        // reset in the middle of a wait
        mem_req = 1;
        cyc("pre_rst_frz", C_FRZ, 2'b00, 2'b00, 0);
        cyc("pre_rst_wait", C_FRZ, 2'b00, 2'b00, 0);
        quiet();
        reset = 0;
        m_sc = 0; m_fc = 0; m_wc = 0; m_err = 1'b0;
        cyc("rst_mid_wait", C_RUN, 2'b00, 2'b00, 0);
        reset = 1;
        cyc("post_rst", C_RUN, 2'b00, 2'b00, 0);
        mem_req = 1; mem_ready = 1;
        cyc("post_rst_ready", C_RUN, 2'b00, 2'b00, 0);
        quiet();
        cyc("post_rst_idle", C_RUN, 2'b00, 2'b00, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
